// File: rtl/pbit_sweep_ctrl_pkg.sv
// Shared constants, FSM encoding and LFSR step helper for the p-bit sweep controller.
// PBITS_DEFAULT stands in for the PBITS value of the shared params include.
package pbit_sweep_ctrl_pkg;

    localparam int PBITS_DEFAULT = 4;
    localparam int FIELD_W       = 32;
    localparam int RNG_W         = 16;

    localparam logic [RNG_W-1:0] LFSR_TAPS         = 16'hB400;
    localparam logic [RNG_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_UPDATE  = 2'd2,
        ST_DONE    = 2'd3
    } sweep_state_e;

    // Galois right-shift step; the taps fold in whenever a one leaves the LSB.
    function automatic logic [RNG_W-1:0] lfsr_step(input logic [RNG_W-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/pbit_lfsr16.sv
// 16-bit Galois LFSR noise source with seed load (zero seed replaced by the default).
module pbit_lfsr16
    import pbit_sweep_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [RNG_W-1:0]  seed,
    input  logic              adv,
    output logic [RNG_W-1:0]  value
);

    logic [RNG_W-1:0] lfsr_r;

    // LFSR register: load has priority over advance; an all-zero seed would lock up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            lfsr_r <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
        end else if (adv) begin
            lfsr_r <= lfsr_step(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign value = lfsr_r;

endmodule

// File: rtl/pbit_sweep_ctrl.sv
// Sweep controller: presents state/index to the field adder and updates one p-bit per step.
// Optional macro PBIT_FLIPCNT_EN adds the flip_count output.
module pbit_sweep_ctrl
    import pbit_sweep_ctrl_pkg::*;
#(
    parameter int PBITS = PBITS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [15:0]               num_sweeps,
    input  logic [PBITS-1:0]          init_state,
    input  logic [15:0]               seed,
    input  logic signed [FIELD_W-1:0] field_in,
    output logic [PBITS-1:0]          state_out,
    output logic signed [31:0]        index_out,
    output logic                      busy,
    output logic                      done
`ifdef PBIT_FLIPCNT_EN
    ,
    output logic [31:0]               flip_count
`endif
);

    localparam int IDX_W = (PBITS > 1) ? $clog2(PBITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PBITS - 1);

    sweep_state_e               state_r, state_next;
    logic [IDX_W-1:0]           idx_r, idx_next;
    logic [15:0]                sweeps_r;
    logic signed [FIELD_W-1:0]  field_q_r;
    logic [PBITS-1:0]           pbits_r;
    logic [RNG_W-1:0]           lfsr_s;
    logic                       lfsr_load_s;
    logic                       lfsr_adv_s;
    logic signed [FIELD_W-1:0]  noise_s;
    logic                       new_bit_s;
    logic                       run_next_s;
    logic                       busy_r;
    logic                       done_r;
    logic signed [31:0]         index_r;

    pbit_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load_s),
        .seed  (seed),
        .adv   (lfsr_adv_s),
        .value (lfsr_s)
    );

    // A tie between field and noise writes 0, hence strict greater-than.
    assign noise_s   = {{(FIELD_W - RNG_W){lfsr_s[RNG_W-1]}}, lfsr_s};
    assign new_bit_s = (field_q_r > noise_s);
    assign run_next_s = (state_next == ST_PRESENT) || (state_next == ST_UPDATE);

    // Next-state and control strobes.
    always_comb begin
        state_next  = state_r;
        idx_next    = idx_r;
        lfsr_load_s = 1'b0;
        lfsr_adv_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    lfsr_load_s = 1'b1;
                    idx_next    = '0;
                    state_next  = (num_sweeps == 16'd0) ? ST_DONE : ST_PRESENT;
                end else begin
                    state_next  = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                state_next = ST_UPDATE;
            end
            ST_UPDATE: begin
                lfsr_adv_s = 1'b1;
                if (idx_r == IDX_LAST) begin
                    idx_next   = '0;
                    state_next = (sweeps_r == 16'd1) ? ST_DONE : ST_PRESENT;
                end else begin
                    idx_next   = idx_r + IDX_W'(1);
                    state_next = ST_PRESENT;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Datapath: run setup, field capture and single-bit update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r     <= '0;
            sweeps_r  <= 16'd0;
            field_q_r <= '0;
            pbits_r   <= '0;
        end else begin
            idx_r <= idx_next;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        pbits_r  <= init_state;
                        sweeps_r <= num_sweeps;
                    end
                end
                ST_PRESENT: begin
                    field_q_r <= field_in;
                end
                ST_UPDATE: begin
                    pbits_r[idx_r] <= new_bit_s;
                    if (idx_r == IDX_LAST) begin
                        sweeps_r <= sweeps_r - 16'd1;
                    end
                end
                default: begin
                    pbits_r <= pbits_r;
                end
            endcase
        end
    end

    // Status outputs registered from the next state so they line up with the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            index_r <= -32'sd1;
        end else begin
            busy_r  <= run_next_s;
            done_r  <= (state_next == ST_DONE);
            index_r <= run_next_s ? $signed({{(32 - IDX_W){1'b0}}, idx_next}) : -32'sd1;
        end
    end

`ifdef PBIT_FLIPCNT_EN
    logic [31:0] flip_cnt_r;

    // Counts updates that actually change the addressed bit; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flip_cnt_r <= 32'd0;
        end else if ((state_r == ST_IDLE) && start) begin
            flip_cnt_r <= 32'd0;
        end else if ((state_r == ST_UPDATE) && (new_bit_s != pbits_r[idx_r])) begin
            flip_cnt_r <= flip_cnt_r + 32'd1;
        end else begin
            flip_cnt_r <= flip_cnt_r;
        end
    end

    assign flip_count = flip_cnt_r;
`endif

    assign state_out = pbits_r;
    assign index_out = index_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_pbit_sweep_ctrl.sv
// Directed bench for pbit_sweep_ctrl with PBITS=4; the field adder is stood in for by a driven field value.
// Exercises flip_count too when PBIT_FLIPCNT_EN is defined.
module tb_pbit_sweep_ctrl;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [15:0]        num_sweeps = 16'd0;
    logic [3:0]         init_state = 4'b0000;
    logic [15:0]        seed = 16'h0000;
    logic signed [31:0] field_in = 32'sd0;
    logic [3:0]         state_out;
    logic signed [31:0] index_out;
    logic               busy;
    logic               done;
`ifdef PBIT_FLIPCNT_EN
    logic [31:0]        flip_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    pbit_sweep_ctrl #(.PBITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_sweeps (num_sweeps),
        .init_state (init_state),
        .seed       (seed),
        .field_in   (field_in),
        .state_out  (state_out),
        .index_out  (index_out),
        .busy       (busy),
        .done       (done)
`ifdef PBIT_FLIPCNT_EN
        ,
        .flip_count (flip_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_step(input logic [15:0] l);
        logic [15:0] n;
        n = {1'b0, l[15:1]};
        if (l[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Pulse start for cycle 0, then watch cycles 1.. until done; busy checked every cycle.
    task automatic run(input logic [3:0] init, input logic [15:0] sd, input logic [15:0] ns,
                       output int done_cyc, output int busy_bad);
        @(negedge clk);
        init_state = init; seed = sd; num_sweeps = ns; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cyc = -1; busy_bad = 0;
        for (int c = 1; c <= 400; c++) begin
            if (c > 1) @(negedge clk);
            if (done === 1'b1) begin
                done_cyc = c;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== (c <= 8 * int'(ns))) busy_bad++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors += 4;
        if (state_out !== 4'b0000) begin miscompares++; $display("FAIL reset_state got %b want 0000", state_out); end
        if (index_out !== -32'sd1) begin miscompares++; $display("FAIL reset_index got %0d want -1", index_out); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        rst = 1'b0;
    endtask

    task automatic test_all_positive();
        int dc, bb;
        field_in = 32'sh1000_0000;
        run(4'b0000, 16'h1234, 16'd1, dc, bb);
        vectors += 5;
        if (dc !== 9) begin miscompares++; $display("FAIL pos_done_cycle got %0d want 9", dc); end
        if (bb !== 0) begin miscompares++; $display("FAIL pos_busy_window got %0d bad cycles want 0", bb); end
        if (state_out !== 4'b1111) begin miscompares++; $display("FAIL pos_state got %b want 1111", state_out); end
        if (index_out !== -32'sd1) begin miscompares++; $display("FAIL pos_done_index got %0d want -1", index_out); end
        @(negedge clk);
        if (done !== 1'b0) begin miscompares++; $display("FAIL pos_done_pulse got %b want 0", done); end
    endtask

    task automatic test_all_negative();
        int dc, bb;
        field_in = -32'sh1000_0000;
        run(4'b1111, 16'hBEEF, 16'd3, dc, bb);
        vectors += 3;
        if (dc !== 25) begin miscompares++; $display("FAIL neg_done_cycle got %0d want 25", dc); end
        if (bb !== 0) begin miscompares++; $display("FAIL neg_busy_window got %0d bad cycles want 0", bb); end
        if (state_out !== 4'b0000) begin miscompares++; $display("FAIL neg_state got %b want 0000", state_out); end
    endtask

    task automatic test_zero_sweeps();
        int idx_bad;
        int dc;
        field_in = 32'sh1000_0000;
        idx_bad = 0; dc = -1;
        @(negedge clk);
        init_state = 4'b1010; num_sweeps = 16'd0; seed = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            if (index_out !== -32'sd1) idx_bad++;
            if (done === 1'b1 && dc < 0) dc = c;
        end
        vectors += 3;
        if (dc !== 1) begin miscompares++; $display("FAIL zero_done_cycle got %0d want 1", dc); end
        if (state_out !== 4'b1010) begin miscompares++; $display("FAIL zero_state got %b want 1010", state_out); end
        if (idx_bad !== 0) begin miscompares++; $display("FAIL zero_index got %0d non-neg cycles want 0", idx_bad); end
    endtask

    // Per-update check of index and written bit against a bench LFSR model.
    task automatic check_noise_seq(input logic [15:0] sd, input logic [15:0] model_seed,
                                   input logic signed [31:0] fld, input string tag);
        logic [15:0] l;
        logic signed [31:0] nz;
        logic exp_bit;
        int bit_bad, idx_bad;
        field_in = fld;
        bit_bad = 0; idx_bad = 0;
        l = model_seed;
        @(negedge clk);
        init_state = 4'b0110; seed = sd; num_sweeps = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int u = 0; u < 8; u++) begin
            if (index_out !== 32'(u % 4)) idx_bad++;
            @(negedge clk);
            @(negedge clk);
            nz = {{16{l[15]}}, l};
            exp_bit = (fld > nz);
            if (state_out[u % 4] !== exp_bit) begin
                bit_bad++;
                $display("FAIL %s_bit%0d got %b want %b", tag, u, state_out[u % 4], exp_bit);
            end
            l = ref_step(l);
        end
        vectors += 3;
        if (bit_bad !== 0) miscompares++;
        if (idx_bad !== 0) begin miscompares++; $display("FAIL %s_index got %0d bad want 0", tag, idx_bad); end
        if (done !== 1'b1) begin miscompares++; $display("FAIL %s_done got %b want 1", tag, done); end
        @(negedge clk);
    endtask

    task automatic test_rst_midrun();
        int done_seen;
        field_in = 32'sh1000_0000;
        @(negedge clk);
        init_state = 4'b0000; seed = 16'h00FF; num_sweeps = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors += 4;
        if (state_out !== 4'b0000) begin miscompares++; $display("FAIL rst_state got %b want 0000", state_out); end
        if (index_out !== -32'sd1) begin miscompares++; $display("FAIL rst_index got %0d want -1", index_out); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done); end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        vectors++;
        if (done_seen !== 0) begin miscompares++; $display("FAIL rst_no_done got %0d pulses want 0", done_seen); end
    endtask

    task automatic test_back_to_back();
        int dc, bb;
        field_in = 32'sh1000_0000;
        run(4'b0000, 16'h0000, 16'd1, dc, bb);
        vectors += 2;
        if (dc !== 9) begin miscompares++; $display("FAIL b2b_first_done got %0d want 9", dc); end
        if (state_out !== 4'b1111) begin miscompares++; $display("FAIL b2b_first_state got %b want 1111", state_out); end
        // start during the DONE cycle must be dropped
        init_state = 4'b0101; num_sweeps = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors += 2;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_done_start_busy got %b want 0", busy); end
        if (state_out !== 4'b1111) begin miscompares++; $display("FAIL b2b_done_start_state got %b want 1111", state_out); end
        field_in = -32'sh1000_0000;
        run(4'b1111, 16'h0BAD, 16'd2, dc, bb);
        vectors += 3;
        if (dc !== 17) begin miscompares++; $display("FAIL b2b_second_done got %0d want 17", dc); end
        if (bb !== 0) begin miscompares++; $display("FAIL b2b_second_busy got %0d bad want 0", bb); end
        if (state_out !== 4'b0000) begin miscompares++; $display("FAIL b2b_second_state got %b want 0000", state_out); end
    endtask

    task automatic test_start_midrun();
        int dc;
        field_in = 32'sh1000_0000;
        dc = -1;
        @(negedge clk);
        init_state = 4'b0000; seed = 16'h4321; num_sweeps = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 3) begin
                start = 1'b1; init_state = 4'b1010; num_sweeps = 16'd0; seed = 16'h0000;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin dc = c; break; end
        end
        start = 1'b0;
        vectors += 2;
        if (dc !== 9) begin miscompares++; $display("FAIL midstart_done got %0d want 9", dc); end
        if (state_out !== 4'b1111) begin miscompares++; $display("FAIL midstart_state got %b want 1111", state_out); end
    endtask

`ifdef PBIT_FLIPCNT_EN
    task automatic test_flip_count();
        int dc, bb;
        field_in = 32'sh1000_0000;
        run(4'b0101, 16'h7777, 16'd1, dc, bb);
        vectors++;
        if (flip_count !== 32'd2) begin miscompares++; $display("FAIL flip_s1 got %0d want 2", flip_count); end
        run(4'b0101, 16'h7777, 16'd4, dc, bb);
        vectors += 2;
        if (flip_count !== 32'd2) begin miscompares++; $display("FAIL flip_s4 got %0d want 2", flip_count); end
        @(negedge clk);
        if (flip_count !== 32'd2) begin miscompares++; $display("FAIL flip_hold got %0d want 2", flip_count); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_all_positive();
        test_all_negative();
        test_zero_sweeps();
        check_noise_seq(16'h0000, 16'hACE1, 32'sd0, "seed0");
        check_noise_seq(16'hACE1, 16'hACE1, 32'sd0, "seedace1");
        check_noise_seq(16'h1234, 16'h1234, 32'sd0, "seed1234");
        check_noise_seq(16'hACE1, 16'hACE1, 32'shFFFF_ACE1, "tie");
        check_noise_seq(16'h8001, 16'h8001, 32'sh0000_4000, "posfield");
        test_rst_midrun();
        test_back_to_back();
        test_start_midrun();
`ifdef PBIT_FLIPCNT_EN
        test_flip_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
